// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state/working-variable types and round helper functions.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_core_round.sv
// One combinational SHA-256 compression round: working variables in, updated variables out.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] kt,
  input  logic [31:0] wt,
  output work_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1    = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + kt + wt;
    t2    = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt.a = t1 + t2;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/sha256_core.sv
// Iterative SHA-256 block compressor, one round per clock, chaining state held between blocks.
// Build option: define SHA224_EN to start from the SHA-224 IV and blank the last digest word.
module sha256_core
  import sha256_pkg::*;
#(
  parameter int BlockWidth  = 512,
  parameter int DigestWidth = 256
) (
  input  logic                   pclk_i,
  input  logic                   preset_ni,
  input  logic                   enable_hash_i,
  input  logic                   reset_hash_i,
  input  logic [BlockWidth-1:0]  block_i,
  output logic                   idle_o,
  output logic                   hold_o,
  output logic [DigestWidth-1:0] digest_o,
  output logic                   digest_valid_o
);

  if (BlockWidth != 512) begin : g_bad_block_width
    $error("sha256_core: BlockWidth must be 512");
  end
  if (DigestWidth != 256) begin : g_bad_digest_width
    $error("sha256_core: DigestWidth must be 256");
  end

`ifdef SHA224_EN
  localparam logic [255:0] Iv = IV224;
`else
  localparam logic [255:0] Iv = IV256;
`endif

  state_e       state_q;
  state_e       state_d;
  logic [255:0] h_q;
  work_t        work_q;
  work_t        work_nxt;
  logic [255:0] work_flat;
  logic [31:0]  w_q [16];
  logic [31:0]  w_new;
  logic [5:0]   t_q;

  // w_q[0] is always W_t; w_new is W_{t+16}, shifted in as the window slides.
  assign w_new     = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
  assign work_flat = work_q;

  sha256_round u_round (
    .cur (work_q),
    .kt  (K[t_q]),
    .wt  (w_q[0]),
    .nxt (work_nxt)
  );

  always_comb begin
    state_d = state_q;
    if (reset_hash_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, HOLD: if (enable_hash_i) state_d = ROUND;
        ROUND:      if (t_q == 6'd63) state_d = FINAL;
        FINAL:      state_d = HOLD;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter saturates at 63 so a stuck ROUND can never run a 65th round.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      h_q    <= Iv;
      work_q <= '0;
      t_q    <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else if (reset_hash_i) begin
      h_q <= Iv;
      t_q <= '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (enable_hash_i) begin
            work_q <= h_q;
            t_q    <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= block_i[BlockWidth-1-32*i -: 32];
          end
        end
        ROUND: begin
          work_q <= work_nxt;
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_new;
          if (t_q != 6'd63) t_q <= t_q + 6'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h_q[32*i +: 32] <= h_q[32*i +: 32] + work_flat[32*i +: 32];
          t_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign idle_o         = (state_q == IDLE);
  assign hold_o         = (state_q == HOLD);
  assign digest_valid_o = (state_q == HOLD);

`ifdef SHA224_EN
  assign digest_o = {h_q[255:32], 32'h0000_0000};
`else
  assign digest_o = h_q;
`endif

endmodule

// File: tb/tb_sha256_core.sv
// Randomized self-checking bench for sha256_core against a behavioural FIPS 180-4 model.
`timescale 1ns/1ps
module tb_sha256_core;

  logic         pclk_i         = 1'b0;
  logic         preset_ni      = 1'b0;
  logic         enable_hash_i  = 1'b0;
  logic         reset_hash_i   = 1'b0;
  logic [511:0] block_i        = '0;
  logic         idle_o;
  logic         hold_o;
  logic [255:0] digest_o;
  logic         digest_valid_o;

  sha256_core dut (
    .pclk_i         (pclk_i),
    .preset_ni      (preset_ni),
    .enable_hash_i  (enable_hash_i),
    .reset_hash_i   (reset_hash_i),
    .block_i        (block_i),
    .idle_o         (idle_o),
    .hold_o         (hold_o),
    .digest_o       (digest_o),
    .digest_valid_o (digest_valid_o)
  );

  always #5 pclk_i = ~pclk_i;

  int           numChecks = 0;
  int           numFails  = 0;
  logic [31:0]  kTab [64];
  logic [255:0] ivRef;
  logic [511:0] padQ [$];
  logic [255:0] midDigest;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] frac32(input real x);
    real f;
    f = x - $floor(x);
    return 32'(longint'($floor(f * 4294967296.0)));
  endfunction

  // Round constants and IV derived from prime roots rather than copied tables.
  task automatic buildConstants();
    int primes [$];
    int p;
    real r;
    bit isPrime;
    p = 2;
    while (primes.size() < 64) begin
      isPrime = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) isPrime = 1'b0;
      if (isPrime) primes.push_back(p);
      p++;
    end
    for (int i = 0; i < 64; i++) begin
      r = $pow(real'(primes[i]), 1.0 / 3.0);
      r = r - (r * r * r - real'(primes[i])) / (3.0 * r * r);
      kTab[i] = frac32(r);
    end
    for (int i = 0; i < 8; i++) ivRef[255-32*i -: 32] = frac32($sqrt(real'(primes[i])));
`ifdef SHA224_EN
    ivRef = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] view(input logic [255:0] h);
`ifdef SHA224_EN
    return {h[255:32], 32'h0};
`else
    return h;
`endif
  endfunction

  // Fully expanded 64-word schedule, then 64 rounds on an 8-entry array.
  function automatic logic [255:0] refCompress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  hw [8];
    logic [31:0]  s0, s1, t1, t2;
    logic [255:0] hout;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) begin
      hw[i] = hin[255-32*i -: 32];
      v[i]  = hw[i];
    end
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kTab[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hw[i] + v[i];
    return hout;
  endfunction

  task automatic padMessage(input string msg);
    logic [7:0]   bytes [$];
    longint       bitLen;
    logic [511:0] blk;
    bitLen = longint'(msg.len()) * 8;
    padQ.delete();
    for (int i = 0; i < msg.len(); i++) bytes.push_back(msg[i]);
    bytes.push_back(8'h80);
    while (bytes.size() % 64 != 56) bytes.push_back(8'h00);
    for (int i = 7; i >= 0; i--) bytes.push_back(8'(bitLen >> (8 * i)));
    for (int b = 0; b < bytes.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = bytes[64*b+j];
      padQ.push_back(blk);
    end
  endtask

  function automatic logic [511:0] randBlock();
    logic [511:0] blk;
    for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom();
    return blk;
  endfunction

  task automatic waitValid(input bit wiggle, output int lat);
    lat = 0;
    while (!digest_valid_o && lat < 100) begin
      if (wiggle) begin
        enable_hash_i = (lat < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
        block_i       = randBlock();
      end
      if (lat == 32) midDigest = digest_o;
      @(posedge pclk_i);
      lat++;
      @(negedge pclk_i);
    end
  endtask

  task automatic applyStimulus(input logic [511:0] blk, input bit wiggle, output int lat);
    @(negedge pclk_i);
    block_i       = blk;
    enable_hash_i = 1'b1;
    @(posedge pclk_i);
    @(negedge pclk_i);
    enable_hash_i = 1'b0;
    waitValid(wiggle, lat);
    enable_hash_i = 1'b0;
  endtask

  task automatic clearHash();
    @(negedge pclk_i);
    reset_hash_i  = 1'b1;
    enable_hash_i = 1'($urandom_range(0, 1));
    @(posedge pclk_i);
    @(negedge pclk_i);
    reset_hash_i  = 1'b0;
    enable_hash_i = 1'b0;
    checkOutput("clear idle/hold/valid", 256'({idle_o, hold_o, digest_valid_o}), 256'(3'b100));
    checkOutput("clear digest", digest_o, view(ivRef));
  endtask

  task automatic runChain(input string name, input bit wiggle, output logic [255:0] hModel);
    int           lat;
    logic [255:0] prev;
    hModel = ivRef;
    clearHash();
    foreach (padQ[b]) begin
      prev = hModel;
      applyStimulus(padQ[b], wiggle, lat);
      hModel = refCompress(hModel, padQ[b]);
      checkOutput({name, " latency"}, 256'(lat), 256'd65);
      checkOutput({name, " mid-round digest"}, midDigest, view(prev));
      checkOutput({name, " digest"}, digest_o, view(hModel));
      checkOutput({name, " idle/hold/valid"}, 256'({idle_o, hold_o, digest_valid_o}), 256'(3'b011));
    end
  endtask

  initial begin
    int           lat;
    logic [255:0] h, h1;
    logic [511:0] b1, b2;
    buildConstants();

    repeat (3) @(negedge pclk_i);
    checkOutput("reset idle/hold/valid", 256'({idle_o, hold_o, digest_valid_o}), 256'(3'b100));
    checkOutput("reset digest", digest_o, view(ivRef));
    preset_ni = 1'b1;
    @(negedge pclk_i);
    checkOutput("post-reset idle", 256'(idle_o), 256'd1);

    padMessage("abc");
    runChain("abc", 1'b0, h);
`ifdef SHA224_EN
    checkOutput("abc sha224 kat", digest_o,
      256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000);
`else
    checkOutput("abc kat", digest_o,
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
    padMessage("");
    runChain("empty", 1'b0, h);
    checkOutput("empty kat", digest_o,
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
    padMessage("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    runChain("two-block", 1'b0, h);
    checkOutput("two-block kat", digest_o,
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
`endif

    // Random multi-block chains with enable and block_i disturbed mid-compression.
    for (int r = 0; r < 4; r++) begin
      padQ.delete();
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) padQ.push_back(randBlock());
      runChain("random chain", 1'b1, h);
    end

    // Abort at round 30 with enable also asserted.
    clearHash();
    @(negedge pclk_i);
    block_i       = randBlock();
    enable_hash_i = 1'b1;
    @(posedge pclk_i);
    @(negedge pclk_i);
    enable_hash_i = 1'b0;
    repeat (30) begin
      @(posedge pclk_i);
      @(negedge pclk_i);
    end
    reset_hash_i  = 1'b1;
    enable_hash_i = 1'b1;
    @(posedge pclk_i);
    @(negedge pclk_i);
    reset_hash_i  = 1'b0;
    enable_hash_i = 1'b0;
    checkOutput("abort idle/hold/valid", 256'({idle_o, hold_o, digest_valid_o}), 256'(3'b100));
    checkOutput("abort digest", digest_o, view(ivRef));
    padMessage("abc");
    applyStimulus(padQ[0], 1'b0, lat);
    checkOutput("rerun latency", 256'(lat), 256'd65);
    checkOutput("rerun digest", digest_o, view(refCompress(ivRef, padQ[0])));

    // Enable held high through completion starts the next block on the first HOLD edge.
    clearHash();
    b1 = randBlock();
    b2 = randBlock();
    @(negedge pclk_i);
    block_i       = b1;
    enable_hash_i = 1'b1;
    @(posedge pclk_i);
    @(negedge pclk_i);
    block_i = b2;
    waitValid(1'b0, lat);
    h1 = refCompress(ivRef, b1);
    checkOutput("held latency 1", 256'(lat), 256'd65);
    checkOutput("held digest 1", digest_o, view(h1));
    @(posedge pclk_i);
    @(negedge pclk_i);
    enable_hash_i = 1'b0;
    checkOutput("held restart idle/hold/valid", 256'({idle_o, hold_o, digest_valid_o}), 256'(3'b000));
    waitValid(1'b0, lat);
    checkOutput("held latency 2", 256'(lat), 256'd65);
    checkOutput("held digest 2", digest_o, view(refCompress(h1, b2)));

    // Asynchronous reset mid-compression, observed before any clock edge.
    @(negedge pclk_i);
    block_i       = randBlock();
    enable_hash_i = 1'b1;
    @(posedge pclk_i);
    @(negedge pclk_i);
    enable_hash_i = 1'b0;
    repeat (10) @(negedge pclk_i);
    #2 preset_ni = 1'b0;
    #1;
    checkOutput("async reset idle/hold/valid", 256'({idle_o, hold_o, digest_valid_o}), 256'(3'b100));
    checkOutput("async reset digest", digest_o, view(ivRef));
    @(negedge pclk_i);
    preset_ni = 1'b1;
    padMessage("abc");
    applyStimulus(padQ[0], 1'b0, lat);
    checkOutput("after async reset latency", 256'(lat), 256'd65);
    checkOutput("after async reset digest", digest_o, view(refCompress(ivRef, padQ[0])));

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sha256_core.md
SHA256_CORE -- requirements
Module: sha256_core

Interface
REQ-001 SHALL have parameter BlockWidth, default 512, message block width; only 512 is legal and elaboration SHALL fail otherwise.
REQ-002 SHALL have parameter DigestWidth, default 256, digest width; only 256 is legal and elaboration SHALL fail otherwise.
REQ-003 SHALL have port pclk_i  input  1  clock; one clock, all state on its rising edge.
REQ-004 SHALL have port preset_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_hash_i  input  1  start compression of block_i.
REQ-006 SHALL have port reset_hash_i  input  1  abort, return chaining state to IV.
REQ-007 SHALL have port block_i  input  BlockWidth  message block; W0 = [511:480], W15 = [31:0].
REQ-008 SHALL have port idle_o  output  1  core in IDLE, chaining state = IV.
REQ-009 SHALL have port hold_o  output  1  block done, chaining state held for next block.
REQ-010 SHALL have port digest_o  output  DigestWidth  {H0..H7}, H0 at [255:224].
REQ-011 SHALL have port digest_valid_o  output  1  digest_o holds a completed result.

Function
REQ-012 SHALL implement the FSM states IDLE, ROUND, FINAL and HOLD.
REQ-013 IDLE/HOLD with enable_hash_i=1 and reset_hash_i=0 at edge E SHALL latch block_i into W[0..15] and load a..h from H, then go to ROUND with t=0.
REQ-014 ROUND SHALL execute one FIPS 180-4 round per cycle on edges E+1..E+64, with the schedule computed on the fly in a 16-word sliding window.
REQ-015 After round t=63, the FSM SHALL go to FINAL; at edge E+65, Hi SHALL become Hi + a..h (mod 2^32 per word) and the FSM SHALL go to HOLD.
REQ-016 Latency SHALL be 65 cycles from the accepting edge to digest_valid_o=1.
REQ-017 All outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path.
REQ-018 idle_o SHALL be 1 only in IDLE, and hold_o and digest_valid_o SHALL be 1 only in HOLD.
REQ-019 digest_o SHALL equal H in every state; H SHALL be constant outside FINAL.
REQ-020 Chaining: enable in HOLD SHALL continue from the current H (multi-block messages); padding is software's responsibility.
REQ-021 reset_hash_i=1 at any edge, in any state including mid-ROUND, SHALL force IDLE and H=IV on that edge and SHALL have priority over enable_hash_i.
REQ-022 enable_hash_i SHALL be ignored in ROUND and FINAL, and block_i changes after acceptance SHALL have no effect.
REQ-023 Round counter SHALL be 6 bits and SHALL NOT wrap into a 65th round; FINAL is entered exactly once per block.
REQ-024 enable_hash_i held high across completion SHALL start the next block on the first HOLD edge.

Reset
REQ-025 On preset_ni low: state=IDLE, H=IV, a..h=0, W=0, t=0; thus idle_o=1, hold_o=0, digest_valid_o=0, digest_o=IV.
REQ-026 Deassertion SHALL take effect on the first pclk_i edge after preset_ni rises, with no further cycles required.

Configuration
REQ-027 Macro SHA224_EN: when defined, IV SHALL be the SHA-224 IV and digest_o[31:0] SHALL read 0 (H7 internal, still chained).
REQ-028 When SHA224_EN is undefined, the core SHALL use the SHA-256 IV and drive digest_o with the full H0..H7.

Structure
REQ-029 Package sha256_pkg SHALL hold the K[0..63] table, the IV256/IV224 constants, the state enum and the Sigma0/Sigma1/sigma0/sigma1/Ch/Maj functions.
REQ-030 A combinational sub-module sha256_round (a..h, Kt, Wt in; next a..h out) SHALL be instantiated once.

Verification
REQ-031 "abc" padded block, enable 1 cycle -> digest_valid_o at E+65, digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-032 Empty-message padded block -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, idle_o=0, hold_o=1.
REQ-033 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second enable in HOLD -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-034 reset_hash_i at round 30 with enable also high -> next cycle idle_o=1, digest_o=IV; a re-run of "abc" then gives the REQ-031 digest.
REQ-035 enable toggled during ROUND, block_i changed after acceptance -> result unchanged, 65-cycle latency unchanged.
REQ-036 With SHA224_EN, "abc" -> digest_o = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
